// File: rtl/axi_r_req_arbiter.sv
// axi_r_req_arbiter: round-robin sharing of one AXI read front end between fetch (port 0) and LSU (port 1)
module axi_r_req_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_OUTS   = 2
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  m0_ren,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic [2:0]            m0_arsize,
  output logic                  m0_raddr_ok,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rdata_ok,
  input  logic                  m0_data_resp,
  input  logic                  m1_ren,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic [2:0]            m1_arsize,
  output logic                  m1_raddr_ok,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rdata_ok,
  input  logic                  m1_data_resp,
  output logic                  ren,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arsize,
  output logic [ID_WIDTH-1:0]   arid,
  input  logic                  raddr_ok,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic                  rdata_ok,
  output logic                  data_resp
);
  localparam int CW = $clog2(MAX_OUTS + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTS);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic grant_q, grant_d, last_q, last_d;
  logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic el0, el1, gnt, req, acc0, acc1, r, ok0, ok1;
  logic unused_rid;
  assign unused_rid = ^rid;
  always_comb begin
    el0 = m0_ren && cnt0_q < MAX_C;
    el1 = m1_ren && cnt1_q < MAX_C;
    gnt = state_q == HOLD ? grant_q : (el0 && el1 ? ~last_q : el1);
    req = !ARESET && (state_q == HOLD ? (grant_q ? m1_ren : m0_ren) : (el0 || el1));
    acc0 = req && raddr_ok && !gnt;
    acc1 = req && raddr_ok && gnt;
    r = rid[0];
    ok0 = !ARESET && rdata_ok && !r;
    ok1 = !ARESET && rdata_ok && r;
    // a dropped request in HOLD releases the lock without an accept
    state_d = req && !raddr_ok ? HOLD : IDLE;
    grant_d = gnt;
    last_d = (acc0 || acc1) ? gnt : last_q;
    cnt0_d = acc0 && !ok0 ? cnt0_q + 1'b1 : (ok0 && !acc0 && cnt0_q != '0 ? cnt0_q - 1'b1 : cnt0_q);
    cnt1_d = acc1 && !ok1 ? cnt1_q + 1'b1 : (ok1 && !acc1 && cnt1_q != '0 ? cnt1_q - 1'b1 : cnt1_q);
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end
  assign ren         = req;
  assign araddr      = req ? (gnt ? m1_araddr : m0_araddr) : '0;
  assign arsize      = req ? (gnt ? m1_arsize : m0_arsize) : '0;
  assign arid        = req ? ID_WIDTH'(gnt) : '0;
  assign m0_raddr_ok = acc0;
  assign m1_raddr_ok = acc1;
  assign data_resp   = !ARESET && (r ? m1_data_resp : m0_data_resp);
  assign m0_rdata    = ARESET ? '0 : sram_rdata;
  assign m1_rdata    = ARESET ? '0 : sram_rdata;
  assign m0_rdata_ok = ok0;
  assign m1_rdata_ok = ok1;
endmodule

// File: tb/tb_axi_r_req_arbiter.sv
// tb_axi_r_req_arbiter: directed self-checking bench for the two-port read arbiter
module tb_axi_r_req_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic m0_ren, m0_data_resp, m1_ren, m1_data_resp, raddr_ok, rdata_ok;
  logic [AW-1:0] m0_araddr, m1_araddr, araddr;
  logic [2:0] m0_arsize, m1_arsize, arsize;
  logic m0_raddr_ok, m0_rdata_ok, m1_raddr_ok, m1_rdata_ok, ren, data_resp;
  logic [DW-1:0] m0_rdata, m1_rdata, sram_rdata;
  logic [IW-1:0] arid, rid;
  int checks = 0;
  int errors = 0;
  bit allow_uf = 1'b0;
  axi_r_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTS(2)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_ren(m0_ren), .m0_araddr(m0_araddr), .m0_arsize(m0_arsize), .m0_raddr_ok(m0_raddr_ok),
    .m0_rdata(m0_rdata), .m0_rdata_ok(m0_rdata_ok), .m0_data_resp(m0_data_resp),
    .m1_ren(m1_ren), .m1_araddr(m1_araddr), .m1_arsize(m1_arsize), .m1_raddr_ok(m1_raddr_ok),
    .m1_rdata(m1_rdata), .m1_rdata_ok(m1_rdata_ok), .m1_data_resp(m1_data_resp),
    .ren(ren), .araddr(araddr), .arsize(arsize), .arid(arid), .raddr_ok(raddr_ok),
    .sram_rdata(sram_rdata), .rid(rid), .rdata_ok(rdata_ok), .data_resp(data_resp)
  );
  always #5 ACLK = ~ACLK;
  always @(negedge ACLK)
    if (!ARESET && !allow_uf && ((m0_rdata_ok && dut.cnt0_q == 0) || (m1_rdata_ok && dut.cnt1_q == 0))) begin
      errors++;
      $display("FAIL underflow: response with zero outstanding (m0 %0b m1 %0b)", m0_rdata_ok, m1_rdata_ok);
    end
  task automatic clr();
    m0_ren = 0; m1_ren = 0; m0_araddr = '0; m1_araddr = '0; m0_arsize = '0; m1_arsize = '0;
    m0_data_resp = 0; m1_data_resp = 0; raddr_ok = 0; rdata_ok = 0; rid = '0; sram_rdata = '0;
  endtask
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask
  task automatic do_reset();
    ARESET = 1;
    clr();
    step();
    ARESET = 0;
    #1;
  endtask
  task automatic test_reset();
    ARESET = 1; m0_ren = 1; m1_ren = 1; raddr_ok = 1; rdata_ok = 1; rid = 4'h1;
    m1_data_resp = 1; sram_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (ren !== 1'b0) begin errors++; $display("FAIL rst_ren got %0b exp 0", ren); end
    checks++; if ({m0_raddr_ok, m1_raddr_ok} !== 2'b00) begin errors++; $display("FAIL rst_raddr_ok got %0b%0b exp 00", m0_raddr_ok, m1_raddr_ok); end
    checks++; if (m1_rdata_ok !== 1'b0) begin errors++; $display("FAIL rst_rdata_ok got %0b exp 0", m1_rdata_ok); end
    checks++; if (data_resp !== 1'b0) begin errors++; $display("FAIL rst_data_resp got %0b exp 0", data_resp); end
    checks++; if (m1_rdata !== '0) begin errors++; $display("FAIL rst_rdata got %0h exp 0", m1_rdata); end
    step();
    clr();
    ARESET = 0;
    #1;
    checks++; if (dut.cnt0_q !== 0 || dut.cnt1_q !== 0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", dut.cnt0_q, dut.cnt1_q); end
  endtask
  task automatic test_single();
    do_reset();
    m0_ren = 1; m0_araddr = 32'h1000; m0_arsize = 3'd2; raddr_ok = 1;
    #1;
    checks++; if (ren !== 1'b1) begin errors++; $display("FAIL single_ren got %0b exp 1", ren); end
    checks++; if (araddr !== 32'h1000 || arsize !== 3'd2) begin errors++; $display("FAIL single_fields got %0h/%0d exp 1000/2", araddr, arsize); end
    checks++; if (arid !== 4'h0) begin errors++; $display("FAIL single_arid got %0h exp 0", arid); end
    checks++; if (m0_raddr_ok !== 1'b1 || m1_raddr_ok !== 1'b0) begin errors++; $display("FAIL single_ok got %0b%0b exp 10", m0_raddr_ok, m1_raddr_ok); end
    step();
    m0_ren = 0;
    #1;
    checks++; if (dut.cnt0_q !== 1) begin errors++; $display("FAIL single_cnt0 got %0d exp 1", dut.cnt0_q); end
    checks++; if (ren !== 1'b0 || araddr !== '0) begin errors++; $display("FAIL single_idle got %0b/%0h exp 0/0", ren, araddr); end
  endtask
  task automatic test_cap();
    do_reset();
    m0_ren = 1; m1_ren = 1; m0_araddr = 32'h100; m1_araddr = 32'h200; m1_arsize = 3'd1; raddr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = i[0];
      #1;
      checks++; if (arid !== IW'(g)) begin errors++; $display("FAIL cap_arid[%0d] got %0h exp %0h", i, arid, g); end
      checks++; if (m0_raddr_ok !== !g || m1_raddr_ok !== g) begin errors++; $display("FAIL cap_ok[%0d] got %0b%0b exp %0b%0b", i, m0_raddr_ok, m1_raddr_ok, !g, g); end
      checks++; if (araddr !== (g ? 32'h200 : 32'h100)) begin errors++; $display("FAIL cap_addr[%0d] got %0h", i, araddr); end
      step();
    end
    #1;
    checks++; if (ren !== 1'b0 || arid !== '0 || araddr !== '0 || arsize !== '0) begin errors++; $display("FAIL cap_ren got %0b/%0h/%0h exp 0/0/0", ren, arid, araddr); end
    checks++; if (m0_raddr_ok !== 1'b0 || m1_raddr_ok !== 1'b0) begin errors++; $display("FAIL cap_blocked got %0b%0b exp 00", m0_raddr_ok, m1_raddr_ok); end
    checks++; if (dut.cnt0_q !== 2 || dut.cnt1_q !== 2) begin errors++; $display("FAIL cap_cnt got %0d/%0d exp 2/2", dut.cnt0_q, dut.cnt1_q); end
  endtask
  task automatic test_hold();
    do_reset();
    m0_ren = 1; m0_araddr = 32'h300; raddr_ok = 1;
    step();
    m1_ren = 1; m1_araddr = 32'h400; raddr_ok = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (arid !== 4'h1 || araddr !== 32'h400 || ren !== 1'b1) begin errors++; $display("FAIL hold_lock[%0d] got %0h/%0h/%0b exp 1/400/1", i, arid, araddr, ren); end
      checks++; if (m0_raddr_ok !== 1'b0 || m1_raddr_ok !== 1'b0) begin errors++; $display("FAIL hold_noacc[%0d] got %0b%0b exp 00", i, m0_raddr_ok, m1_raddr_ok); end
      step();
    end
    raddr_ok = 1;
    #1;
    checks++; if (m1_raddr_ok !== 1'b1 || m0_raddr_ok !== 1'b0 || arid !== 4'h1) begin errors++; $display("FAIL hold_acc got %0b%0b/%0h exp 01/1", m0_raddr_ok, m1_raddr_ok, arid); end
    step();
    #1;
    checks++; if (m0_raddr_ok !== 1'b1 || arid !== 4'h0 || araddr !== 32'h300) begin errors++; $display("FAIL hold_next got %0b/%0h exp 1/0", m0_raddr_ok, arid); end
    step();
    raddr_ok = 0;
    step();
    m1_ren = 0; raddr_ok = 1;
    #1;
    checks++; if (ren !== 1'b0 || m1_raddr_ok !== 1'b0) begin errors++; $display("FAIL hold_drop got %0b/%0b exp 0/0", ren, m1_raddr_ok); end
    step();
    m1_ren = 1;
    #1;
    checks++; if (dut.cnt1_q !== 1 || m1_raddr_ok !== 1'b1) begin errors++; $display("FAIL hold_reidle got %0d/%0b exp 1/1", dut.cnt1_q, m1_raddr_ok); end
    step();
    clr();
  endtask
  task automatic test_response();
    do_reset();
    m1_ren = 1; m1_araddr = 32'h500; raddr_ok = 1;
    step();
    m1_ren = 0; raddr_ok = 0;
    rid = 4'h1; rdata_ok = 1; m1_data_resp = 1; m0_data_resp = 0; sram_rdata = 32'h1234_5678;
    #1;
    checks++; if (data_resp !== 1'b1) begin errors++; $display("FAIL resp_ready got %0b exp 1", data_resp); end
    checks++; if (m1_rdata_ok !== 1'b1 || m0_rdata_ok !== 1'b0) begin errors++; $display("FAIL resp_route got %0b%0b exp 01", m0_rdata_ok, m1_rdata_ok); end
    checks++; if (m1_rdata !== 32'h1234_5678 || m0_rdata !== 32'h1234_5678) begin errors++; $display("FAIL resp_data got %0h/%0h exp 12345678", m0_rdata, m1_rdata); end
    step();
    rdata_ok = 0;
    #1;
    checks++; if (dut.cnt1_q !== 0) begin errors++; $display("FAIL resp_cnt1 got %0d exp 0", dut.cnt1_q); end
    rid = 4'h2;
    #1;
    checks++; if (data_resp !== 1'b0) begin errors++; $display("FAIL resp_sel0 got %0b exp 0", data_resp); end
    m0_data_resp = 1; m1_data_resp = 0;
    #1;
    checks++; if (data_resp !== 1'b1) begin errors++; $display("FAIL resp_sel0b got %0b exp 1", data_resp); end
    clr();
  endtask
  task automatic test_back_to_back();
    do_reset();
    m0_ren = 1; m0_araddr = 32'h600; raddr_ok = 1;
    step();
    step();
    checks++; if (dut.cnt0_q !== 2) begin errors++; $display("FAIL b2b_full got %0d exp 2", dut.cnt0_q); end
    rid = 4'h0; rdata_ok = 1; m0_data_resp = 1;
    #1;
    checks++; if (ren !== 1'b0 || m0_raddr_ok !== 1'b0) begin errors++; $display("FAIL b2b_blocked got %0b/%0b exp 0/0", ren, m0_raddr_ok); end
    checks++; if (m0_rdata_ok !== 1'b1 || data_resp !== 1'b1) begin errors++; $display("FAIL b2b_resp got %0b/%0b exp 1/1", m0_rdata_ok, data_resp); end
    step();
    #1;
    checks++; if (dut.cnt0_q !== 1 || m0_raddr_ok !== 1'b1) begin errors++; $display("FAIL b2b_freed got %0d/%0b exp 1/1", dut.cnt0_q, m0_raddr_ok); end
    step();
    rdata_ok = 0;
    #1;
    checks++; if (dut.cnt0_q !== 1 || m0_raddr_ok !== 1'b1) begin errors++; $display("FAIL b2b_same got %0d/%0b exp 1/1", dut.cnt0_q, m0_raddr_ok); end
    step();
    checks++; if (dut.cnt0_q !== 2) begin errors++; $display("FAIL b2b_refill got %0d exp 2", dut.cnt0_q); end
    clr();
  endtask
  task automatic test_underflow();
    do_reset();
    allow_uf = 1;
    rid = 4'h0; rdata_ok = 1; m0_data_resp = 1;
    step();
    rdata_ok = 0;
    #1;
    checks++; if (dut.cnt0_q !== 0) begin errors++; $display("FAIL uf_hold got %0d exp 0", dut.cnt0_q); end
    allow_uf = 0;
    clr();
  endtask
  task automatic test_reset_in_hold();
    do_reset();
    m0_ren = 1; raddr_ok = 1;
    step();
    step();
    m1_ren = 1; m1_araddr = 32'h700; raddr_ok = 0;
    step();
    #1;
    checks++; if (arid !== 4'h1 || ren !== 1'b1) begin errors++; $display("FAIL rh_hold got %0h/%0b exp 1/1", arid, ren); end
    ARESET = 1; raddr_ok = 1;
    #1;
    checks++; if (ren !== 1'b0 || arid !== '0 || araddr !== '0 || m1_raddr_ok !== 1'b0) begin errors++; $display("FAIL rh_zero got %0b/%0h/%0h/%0b exp 0", ren, arid, araddr, m1_raddr_ok); end
    checks++; if (dut.cnt0_q !== 0) begin errors++; $display("FAIL rh_cnt got %0d exp 0", dut.cnt0_q); end
    step();
    ARESET = 0;
    #1;
    checks++; if (arid !== 4'h0 || m0_raddr_ok !== 1'b1 || m1_raddr_ok !== 1'b0) begin errors++; $display("FAIL rh_first got %0h/%0b%0b exp 0/10", arid, m0_raddr_ok, m1_raddr_ok); end
    step();
    clr();
  endtask
  initial begin
    clr();
    test_reset();
    test_single();
    test_cap();
    test_hold();
    test_response();
    test_back_to_back();
    test_underflow();
    test_reset_in_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
